// File: rtl/inport_feeder.sv
// inport_feeder: DEPTH-entry circular FIFO that queues host-loaded words and
// presents them, oldest first, on the CPU in-port. When the queue is empty the
// in-port keeps showing the last word the CPU consumed.
//
// Handshakes:
//   load side   - a word transfers on a rising edge where load_valid && load_ready.
//                 load_ready depends only on registered occupancy, never on
//                 inport_rd, so a full queue refuses a load even if a read frees
//                 an entry in that same cycle.
//   in-port side - inport_valid flags an unconsumed head word; a read transfers
//                 on a rising edge where inport_rd && inport_valid. A strobe with
//                 the queue empty is refused and recorded in underflow_err.
module inport_feeder #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       load_valid,
  input  logic [WIDTH-1:0]           load_data,
  output logic                       load_ready,
  input  logic                       inport_rd,
  output logic [WIDTH-1:0]           inport_data,
  output logic                       inport_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow_err,
  output logic                       underflow_err,
  input  logic                       clear_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [WIDTH-1:0] lastWord;
  logic             notEmpty;
  logic             loadAcc;
  logic             readAcc;
  logic             overflowEvt;
  logic             underflowEvt;

  // Accept/refuse decisions, all derived from registered occupancy.
  always_comb begin
    notEmpty     = (count != '0);
    load_ready   = (count < FULL_COUNT);
    loadAcc      = load_valid && load_ready;
    readAcc      = inport_rd && notEmpty;
    overflowEvt  = load_valid && !load_ready;
    underflowEvt = inport_rd && !notEmpty;
  end

  // Head word while queued, otherwise hold the last consumed word so stale
  // storage never leaks out while the queue is empty.
  always_comb begin
    inport_valid = notEmpty;
    inport_data  = notEmpty ? mem[rdPtr] : lastWord;
  end

  // Storage write; contents are not reset since they are masked when empty.
  always_ff @(posedge Clock) begin
    if (!Reset && loadAcc) begin
      mem[wrPtr] <= load_data;
    end
  end

  // Pointers, occupancy and last consumed word. Pointer width equals log2
  // DEPTH, so the increment wraps from DEPTH-1 to 0 on its own.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      lastWord <= '0;
    end else begin
      if (loadAcc) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (readAcc) begin
        rdPtr    <= rdPtr + 1'b1;
        lastWord <= mem[rdPtr];
      end
      case ({loadAcc, readAcc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new event in the clearing cycle wins over the clear.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      overflow_err  <= overflowEvt  || (overflow_err  && !clear_err);
      underflow_err <= underflowEvt || (underflow_err && !clear_err);
    end
  end

endmodule

// File: tb/tb_inport_feeder.sv
// Directed bench for inport_feeder (DEPTH=4, WIDTH=32).
module tb_inport_feeder;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             Clock;
  logic             Reset;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             inport_rd;
  logic [WIDTH-1:0] inport_data;
  logic             inport_valid;
  logic [2:0]       count;
  logic             overflow_err;
  logic             underflow_err;
  logic             clear_err;

  int checks;
  int errors;
  logic [WIDTH-1:0] exp_q[$];

  inport_feeder #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_ready    (load_ready),
    .inport_rd     (inport_rd),
    .inport_data   (inport_data),
    .inport_valid  (inport_valid),
    .count         (count),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err),
    .clear_err     (clear_err)
  );

  // Clock generation.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge pass, then return inputs to idle.
  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic lv, input logic [WIDTH-1:0] ld,
                      input logic rd, input logic ce);
    load_valid = lv;
    load_data  = ld;
    inport_rd  = rd;
    clear_err  = ce;
    @(posedge Clock);
    #1;
    load_valid = 1'b0;
    load_data  = '0;
    inport_rd  = 1'b0;
    clear_err  = 1'b0;
  endtask

  task automatic loadWord(input logic [WIDTH-1:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic readExpect(input string tag, input logic [WIDTH-1:0] d);
    checkVal(tag, inport_data, d);
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    Reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    inport_rd  = 1'b0;
    clear_err  = 1'b0;
    repeat (2) @(posedge Clock);
    #1;

    // Reset state
    checkVal("rst_count", 32'(count), 0);
    checkVal("rst_valid", 32'(inport_valid), 0);
    checkVal("rst_data", inport_data, 0);
    checkVal("rst_ready", 32'(load_ready), 1);
    checkVal("rst_ovf", 32'(overflow_err), 0);
    checkVal("rst_udf", 32'(underflow_err), 0);
    Reset = 1'b0;

    // Single word: zero-latency visibility, then held after consumption
    loadWord(32'h88);
    checkVal("one_data", inport_data, 32'h88);
    checkVal("one_valid", 32'(inport_valid), 1);
    checkVal("one_count", 32'(count), 1);
    step(1'b0, '0, 1'b1, 1'b0);
    checkVal("one_rd_count", 32'(count), 0);
    checkVal("one_rd_valid", 32'(inport_valid), 0);
    checkVal("one_rd_hold", inport_data, 32'h88);

    // Fill, overflow, drain in order
    loadWord(32'h11); loadWord(32'h22); loadWord(32'h33); loadWord(32'h44);
    checkVal("full_count", 32'(count), 4);
    checkVal("full_ready", 32'(load_ready), 0);
    loadWord(32'h55);
    checkVal("ovf_count", 32'(count), 4);
    checkVal("ovf_flag", 32'(overflow_err), 1);
    checkVal("ovf_head", inport_data, 32'h11);
    readExpect("drain0", 32'h11);
    readExpect("drain1", 32'h22);
    readExpect("drain2", 32'h33);
    readExpect("drain3", 32'h44);
    checkVal("drain_count", 32'(count), 0);
    checkVal("drain_hold", inport_data, 32'h44);
    checkVal("drain_udf", 32'(underflow_err), 0);
    step(1'b0, '0, 1'b0, 1'b1);
    checkVal("clr_ovf", 32'(overflow_err), 0);

    // Full queue: load and read together -> read taken, load dropped
    loadWord(32'h11); loadWord(32'h22); loadWord(32'h33); loadWord(32'h44);
    step(1'b1, 32'h55, 1'b1, 1'b0);
    checkVal("fullrw_count", 32'(count), 3);
    checkVal("fullrw_ovf", 32'(overflow_err), 1);
    checkVal("fullrw_head", inport_data, 32'h22);
    readExpect("fullrw_d0", 32'h22);
    readExpect("fullrw_d1", 32'h33);
    readExpect("fullrw_d2", 32'h44);
    step(1'b0, '0, 1'b0, 1'b1);

    // Empty queue: read with load -> underflow, load still accepted
    step(1'b1, 32'hA5, 1'b1, 1'b0);
    checkVal("udf_flag", 32'(underflow_err), 1);
    checkVal("udf_count", 32'(count), 1);
    checkVal("udf_data", inport_data, 32'hA5);
    checkVal("udf_noovf", 32'(overflow_err), 0);
    readExpect("udf_rd", 32'hA5);
    // Clear and a new underflow in the same cycle: set wins
    step(1'b0, '0, 1'b1, 1'b1);
    checkVal("setwins_udf", 32'(underflow_err), 1);
    checkVal("setwins_hold", inport_data, 32'hA5);
    step(1'b0, '0, 1'b0, 1'b1);
    checkVal("clr_udf", 32'(underflow_err), 0);

    // Wrap: two queued, six load/read pairs, then drain; FIFO order via exp_q
    loadWord(32'hA0); exp_q.push_back(32'hA0);
    loadWord(32'hA1); exp_q.push_back(32'hA1);
    for (int i = 0; i < 6; i++) begin
      checkVal("wrap_head", inport_data, exp_q.pop_front());
      step(1'b1, 32'hB0 + 32'(i), 1'b1, 1'b0);
      exp_q.push_back(32'hB0 + 32'(i));
      checkVal("wrap_count", 32'(count), 2);
    end
    while (exp_q.size() > 0) readExpect("wrap_drain", exp_q.pop_front());
    checkVal("wrap_empty", 32'(count), 0);
    checkVal("wrap_hold", inport_data, 32'hB5);

    // Set both flags, then clear both
    step(1'b0, '0, 1'b1, 1'b0);
    loadWord(32'hC0); loadWord(32'hC1); loadWord(32'hC2); loadWord(32'hC3);
    loadWord(32'hC4);
    checkVal("both_udf", 32'(underflow_err), 1);
    checkVal("both_ovf", 32'(overflow_err), 1);
    step(1'b0, '0, 1'b0, 1'b1);
    checkVal("clr_both_ovf", 32'(overflow_err), 0);
    checkVal("clr_both_udf", 32'(underflow_err), 0);
    checkVal("clr_both_count", 32'(count), 4);

    // Reset with count=3, flags set and a load offered
    loadWord(32'hC5);
    readExpect("pre_rst_rd", 32'hC0);
    checkVal("pre_rst_count", 32'(count), 3);
    checkVal("pre_rst_ovf", 32'(overflow_err), 1);
    Reset = 1'b1;
    step(1'b1, 32'h77, 1'b1, 1'b0);
    Reset = 1'b0;
    checkVal("mid_rst_count", 32'(count), 0);
    checkVal("mid_rst_valid", 32'(inport_valid), 0);
    checkVal("mid_rst_data", inport_data, 0);
    checkVal("mid_rst_ovf", 32'(overflow_err), 0);
    checkVal("mid_rst_udf", 32'(underflow_err), 0);
    checkVal("mid_rst_ready", 32'(load_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inport_feeder.md
INPORT_FEEDER -- requirements
Module: inport_feeder

Interface
REQ-001 Parameter DEPTH, default 4, number of queued words (power of 2, minimum 2).
REQ-002 Parameter WIDTH, default 32, data word width.
REQ-003 Clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-005 load_valid  input  1  host offers load_data this cycle.
REQ-006 load_data  input  WIDTH  word to enqueue for the CPU in-port.
REQ-007 load_ready  output  1  queue can accept a word this cycle.
REQ-008 inport_rd  input  1  CPU in-port read strobe; consumes the current head word this cycle.
REQ-009 inport_data  output  WIDTH  value driven onto the CPU in-port input.
REQ-010 inport_valid  output  1  inport_data is an unconsumed queued word.
REQ-011 count  output  log2(DEPTH)+1  number of queued words.
REQ-012 overflow_err  output  1  sticky: load attempted while full.
REQ-013 underflow_err  output  1  sticky: inport_rd while empty.
REQ-014 clear_err  input  1  clears both sticky error flags.

Function
REQ-015 The block SHALL be a DEPTH-entry circular FIFO with write pointer, read pointer and occupancy counter, feeding the CPU in-port.
REQ-016 load_ready SHALL equal (count < DEPTH), combinational from registered state only; it SHALL NOT depend on inport_rd.
REQ-017 A load is accepted when load_valid=1 and load_ready=1: word written at write pointer, write pointer increments modulo DEPTH.
REQ-018 A read is accepted when inport_rd=1 and count>0: head word copied to last_word register, read pointer increments modulo DEPTH.
REQ-019 count SHALL update per edge as count + accepted_load - accepted_read; simultaneous accepted load and read leave count unchanged.
REQ-020 inport_valid SHALL equal (count > 0).
REQ-021 inport_data SHALL equal the head entry when count>0, otherwise last_word (last consumed word, held indefinitely).
REQ-022 Latency: a word accepted into an empty queue on edge N SHALL appear on inport_data with inport_valid=1 immediately after edge N.
REQ-023 Load with load_valid=1 while full SHALL be dropped and set overflow_err, even if inport_rd is accepted in the same cycle.
REQ-024 inport_rd while empty SHALL set underflow_err and change no pointer, count or last_word; a load in the same cycle is still accepted (count becomes 1).
REQ-025 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; data order is strictly first-in first-out.
REQ-026 clear_err=1 SHALL clear both error flags on the edge; if a new error event occurs in the same cycle, the flag SHALL be set (set wins).
REQ-027 Error flags SHALL NOT block loads or reads.

Reset
REQ-028 On Reset=1 at a rising edge: pointers=0, count=0, last_word=0, overflow_err=0, underflow_err=0; hence inport_data=0, inport_valid=0, load_ready=1.
REQ-029 Reset SHALL take priority over load_valid, inport_rd and clear_err in the same cycle; queued words are discarded.
REQ-030 Queue storage contents need not be reset; they SHALL never be visible while count=0.

Verification
REQ-031 Reset, then load 0x00000088 -> next cycle inport_data=0x88, inport_valid=1, count=1; pulse inport_rd -> count=0, inport_valid=0, inport_data stays 0x88.
REQ-032 Load 0x11,0x22,0x33,0x44 (DEPTH=4) -> count=4, load_ready=0; load 0x55 -> dropped, overflow_err=1; four reads return 0x11,0x22,0x33,0x44 in order.
REQ-033 Full queue, load_valid and inport_rd together -> head 0x11 consumed, 0x55 dropped, count=3, overflow_err=1.
REQ-034 Empty queue, inport_rd with load 0xA5 same cycle -> underflow_err=1, count=1, inport_data=0xA5.
REQ-035 Six load/read pairs cycling pointers past wrap -> FIFO order preserved; clear_err -> both flags 0 next cycle.
REQ-036 Reset asserted with count=3 and load_valid=1 -> count=0, inport_valid=0, inport_data=0, all flags 0.
